fetch_controller: RTL and testbench

Multi-cycle instruction fetch sequencer sitting between the PC/control unit and `instructionMemory`. Owns the program counter, drives the memory's `En`/`address` pins, captures the registered read into an instruction register (IR), and hands each instruction to decode over a valid/ready handshake. Supports branch/jump redirect and halt from the control unit.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_prefetch_buf.sv | 69 ++++++
 rtl/fetch_controller.sv | 169 ++++++++++++++++
 tb/tb_fetch_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding, default widths and the PC value loaded on reset.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W   = 16;
  localparam int unsigned DEF_INSTR_W  = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_prefetch_buf.sv
// One-entry prefetch buffer for the fetch sequencer. Tracks a single
// outstanding read (data returns exactly one cycle after issue) and holds
// one fetched instruction with its address until the controller takes it.
// Only instantiated when FETCH_PREFETCH_EN is defined.
module fetch_prefetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,       // redirect: drop buffer and in-flight read
  input  logic               issue_i,     // prefetch read driven to memory this cycle
  input  logic               fill_i,      // capture returning data into the buffer
  input  logic               take_i,      // buffer content moved into the IR
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               pf_valid_o,
  output logic               pf_inflight_o,
  output logic [INSTR_W-1:0] pf_buf_o,
  output logic [ADDR_W-1:0]  pf_pc_o
);

  logic               pf_valid_q, pf_valid_d;
  logic               pf_inflight_q, pf_inflight_d;
  logic [INSTR_W-1:0] pf_buf_q, pf_buf_d;
  logic [ADDR_W-1:0]  pf_pc_q, pf_pc_d;

  // Next-state for the buffer; a clear beats any fill or take
  always_comb begin
    pf_valid_d    = pf_valid_q;
    pf_buf_d      = pf_buf_q;
    pf_pc_d       = pf_pc_q;
    pf_inflight_d = issue_i;
    if (fill_i) begin
      pf_valid_d = 1'b1;
      pf_buf_d   = data_i;
      pf_pc_d    = pc_i;
    end else if (take_i) begin
      pf_valid_d = 1'b0;
    end
    if (clr_i) begin
      pf_valid_d    = 1'b0;
      pf_inflight_d = 1'b0;
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pf_valid_q    <= 1'b0;
      pf_inflight_q <= 1'b0;
      pf_buf_q      <= '0;
      pf_pc_q       <= '0;
    end else begin
      pf_valid_q    <= pf_valid_d;
      pf_inflight_q <= pf_inflight_d;
      pf_buf_q      <= pf_buf_d;
      pf_pc_q       <= pf_pc_d;
    end
  end

  assign pf_valid_o    = pf_valid_q;
  assign pf_inflight_o = pf_inflight_q;
  assign pf_buf_o      = pf_buf_q;
  assign pf_pc_o       = pf_pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Multi-cycle instruction fetch sequencer. Owns the PC, drives the
// instruction memory (registered read, data valid one cycle after mem_en),
// captures the result into the IR and offers it to decode over valid/ready.
// Redirect reloads the PC and discards held/in-flight work; halt parks the
// FSM in IDLE after the held instruction is accepted.
// Optional feature macro: FETCH_PREFETCH_EN adds a one-entry prefetch
// buffer so a new read overlaps with the IR waiting for decode.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               busy
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               handshake;
  logic               issue;

  assign handshake = ir_valid_q && ir_ready;

`ifdef FETCH_PREFETCH_EN
  logic               pf_valid;
  logic               pf_inflight;
  logic [INSTR_W-1:0] pf_buf;
  logic [ADDR_W-1:0]  pf_pc;
  logic               pf_issue;
  logic               pf_fill;
  logic               pf_take;

  fetch_prefetch_buf #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_pf (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (redirect),
    .issue_i       (pf_issue),
    .fill_i        (pf_fill),
    .take_i        (pf_take),
    .data_i        (mem_instr),
    .pc_i          (pc_q),
    .pf_valid_o    (pf_valid),
    .pf_inflight_o (pf_inflight),
    .pf_buf_o      (pf_buf),
    .pf_pc_o       (pf_pc)
  );
`endif

  // FSM next-state, datapath next values and memory request
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    issue      = 1'b0;
`ifdef FETCH_PREFETCH_EN
    pf_issue   = 1'b0;
    pf_fill    = 1'b0;
    pf_take    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ir_d       = mem_instr;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
        pc_d       = pc_q + ADDR_W'(1);
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
`ifdef FETCH_PREFETCH_EN
        // Overlap the next read with the IR wait; halt and redirect stop it
        pf_issue = !pf_valid && !pf_inflight && !halt && !redirect;
        issue    = pf_issue;
        if (handshake) begin
          if (pf_valid) begin
            ir_d    = pf_buf;
            ir_pc_d = pf_pc;
            pf_take = 1'b1;
          end else if (pf_inflight) begin
            // Returning prefetch goes straight to the IR
            ir_d    = mem_instr;
            ir_pc_d = pc_q;
            pc_d    = pc_q + ADDR_W'(1);
          end else begin
            ir_valid_d = 1'b0;
            // A read issued this cycle already covers the ISSUE step
            if (pf_issue)  state_d = ST_WAIT;
            else if (halt) state_d = ST_IDLE;
            else           state_d = ST_ISSUE;
          end
        end else if (pf_inflight) begin
          pf_fill = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
        end
`else
        if (handshake) begin
          ir_valid_d = 1'b0;
          state_d    = halt ? ST_IDLE : ST_ISSUE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect lands after any same-cycle handshake and beats halt
    if (redirect) begin
      pc_d = redirect_pc;
      if (state_q != ST_IDLE) begin
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = 1'b0;
        state_d    = ST_ISSUE;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign mem_en   = issue;
  assign mem_addr = issue ? pc_q : '0;
  assign ir_valid = ir_valid_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus a randomized phase.
// The reference model tracks only the address of the next instruction
// decode should receive; every presented IR must be mem[that address].
// Define FETCH_PREFETCH_EN for both bench and RTL to exercise the buffer.
module tb_fetch_controller;

`ifdef FETCH_PREFETCH_EN
  localparam int GAP      = 2;
  localparam int HOLD_ENS = 1;
`else
  localparam int GAP      = 3;
  localparam int HOLD_ENS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_instr = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        busy;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_pc = 16'h0000;
  int          checks = 0;
  int          failures = 0;
  int          en_cnt = 0;

  fetch_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_instr   (mem_instr),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory; output held while mem_en is low
  always @(posedge clk) begin
    if (mem_en) mem_instr <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check at the negedge against the model, advance the model
  // with this cycle's inputs, then land #1 after the rising edge.
  task automatic step();
    logic hs, p_hold, p_reset;
    @(negedge clk);
    if (ir_valid) begin
      chk("ir_data", {16'h0, ir}, {16'h0, mem[exp_pc]});
      chk("ir_pc", {16'h0, ir_pc}, {16'h0, exp_pc});
      chk("valid_busy", {31'h0, busy}, 32'd1);
    end
    if (!busy) chk("idle_mem_en", {31'h0, mem_en}, 32'd0);
    if (mem_en) en_cnt++;
    hs      = ir_valid && ir_ready && !reset;
    p_hold  = ir_valid && !ir_ready && !redirect && !reset;
    p_reset = reset;
    if (hs) $display("ACCEPT ir_pc=%h ir=%h", ir_pc, ir);
    if (reset) exp_pc = 16'h0000;
    else begin
      if (hs) exp_pc = exp_pc + 16'd1;
      if (redirect) exp_pc = redirect_pc;
    end
    @(posedge clk);
    #1;
    if (p_reset) begin
      chk("rst_ir_valid", {31'h0, ir_valid}, 32'd0);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_mem_en", {31'h0, mem_en}, 32'd0);
      chk("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
      chk("rst_ir", {16'h0, ir}, 32'd0);
      chk("rst_ir_pc", {16'h0, ir_pc}, 32'd0);
    end
    if (p_hold) chk("hold_valid", {31'h0, ir_valid}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0; ir_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ir_valid && n < 10) begin step(); n++; end
    if (!ir_valid) chk({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int stall;
    logic p_red, p_rst;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h5678; mem[3] = 16'h9ABC;

    // Basic sequence and throughput
    do_reset();
    start = 1'b1; ir_ready = 1'b1;
    step(); start = 1'b0;
    chk("issue_en", {31'h0, mem_en}, 32'd1);
    chk("issue_addr", {16'h0, mem_addr}, 32'h0000);
    chk("issue_busy", {31'h0, busy}, 32'd1);
    step();
    chk("wait_en", {31'h0, mem_en}, 32'd0);
    chk("wait_valid", {31'h0, ir_valid}, 32'd0);
    step();
    chk("first_valid", {31'h0, ir_valid}, 32'd1);
    chk("first_ir", {16'h0, ir}, 32'h1234);
    n = 0;
    do begin step(); n++; end while (!ir_valid && n < 8);
    chk("gap", 32'(n), 32'(GAP));
    chk("second_ir", {16'h0, ir}, 32'hABCD);
    chk("second_pc", {16'h0, ir_pc}, 32'h0001);

    // Back-pressure while holding ABCD
    ir_ready = 1'b0; en_cnt = 0;
    repeat (5) begin
      step();
      chk("stall_ir", {16'h0, ir}, 32'hABCD);
      chk("stall_valid", {31'h0, ir_valid}, 32'd1);
    end
    chk("stall_mem_en_cnt", 32'(en_cnt), 32'(HOLD_ENS));
    ir_ready = 1'b1;
    step();
    wait_valid("after_stall");
    chk("after_stall_ir", {16'h0, ir}, 32'h5678);
    chk("after_stall_pc", {16'h0, ir_pc}, 32'h0002);

    // Redirect during the WAIT of address 1
    do_reset();
    start = 1'b1; ir_ready = 1'b1;
    step(); start = 1'b0;
    n = 0;
    while (!(mem_en && mem_addr == 16'h0001) && n < 10) begin step(); n++; end
    chk("reach_addr1", {31'h0, mem_en}, 32'd1);
    step();
    redirect = 1'b1; redirect_pc = 16'h0003;
    step(); redirect = 1'b0;
    chk("redir_issue_en", {31'h0, mem_en}, 32'd1);
    chk("redir_issue_addr", {16'h0, mem_addr}, 32'h0003);
    chk("redir_v0", {31'h0, ir_valid}, 32'd0);
    step();
    chk("redir_v1", {31'h0, ir_valid}, 32'd0);
    step();
    chk("redir_valid", {31'h0, ir_valid}, 32'd1);
    chk("redir_ir", {16'h0, ir}, 32'h9ABC);
    chk("redir_pc", {16'h0, ir_pc}, 32'h0003);

    // Halt at the handshake of 1234, then resume
    do_reset();
    start = 1'b1;
    step(); start = 1'b0;
    wait_valid("halt_first");
    halt = 1'b1;
    repeat (2) begin step(); chk("halt_hold_en", {31'h0, mem_en}, 32'd0); end
    ir_ready = 1'b1;
    step();
    chk("halt_busy", {31'h0, busy}, 32'd0);
    chk("halt_mem_en", {31'h0, mem_en}, 32'd0);
    chk("halt_valid", {31'h0, ir_valid}, 32'd0);
    halt = 1'b0; ir_ready = 1'b0;
    repeat (3) begin
      step();
      chk("halt_idle_en", {31'h0, mem_en}, 32'd0);
      chk("halt_idle_busy", {31'h0, busy}, 32'd0);
    end
    start = 1'b1;
    step(); start = 1'b0;
    chk("resume_en", {31'h0, mem_en}, 32'd1);
    chk("resume_addr", {16'h0, mem_addr}, 32'h0001);
    ir_ready = 1'b1;
    wait_valid("resume");
    chk("resume_ir", {16'h0, ir}, 32'hABCD);

    // Redirect in IDLE to FFFF, then wrap
    do_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step(); redirect = 1'b0;
    chk("idle_redir_busy", {31'h0, busy}, 32'd0);
    start = 1'b1; ir_ready = 1'b1;
    step(); start = 1'b0;
    chk("wrap_issue_addr", {16'h0, mem_addr}, 32'hFFFF);
    wait_valid("wrap");
    chk("wrap_ir_pc", {16'h0, ir_pc}, 32'hFFFF);
    chk("wrap_ir", {16'h0, ir}, {16'h0, mem[16'hFFFF]});
    n = 0;
    while (!mem_en && n < 8) begin step(); n++; end
    chk("wrap_next_en", {31'h0, mem_en}, 32'd1);
    chk("wrap_next_addr", {16'h0, mem_addr}, 32'h0000);

    // Reset during WAIT discards the read and reloads the PC
    do_reset();
    redirect = 1'b1; redirect_pc = 16'h0002;
    step(); redirect = 1'b0;
    start = 1'b1; ir_ready = 1'b1;
    step(); start = 1'b0;
    step();
    reset = 1'b1;
    step(); reset = 1'b0;
    repeat (3) begin
      step();
      chk("post_rst_valid", {31'h0, ir_valid}, 32'd0);
      chk("post_rst_busy", {31'h0, busy}, 32'd0);
    end
    start = 1'b1;
    step(); start = 1'b0;
    chk("post_rst_addr", {16'h0, mem_addr}, 32'h0000);
    chk("post_rst_en", {31'h0, mem_en}, 32'd1);

    // Randomized traffic
    stall = 0;
    for (int c = 0; c < 1500; c++) begin
      ir_ready = ($urandom % 4) != 0;
      redirect = ($urandom % 25) == 0;
      case ($urandom % 4)
        0: redirect_pc = 16'hFFFF;
        1: redirect_pc = 16'hFFFE;
        2: redirect_pc = 16'($urandom % 8);
        default: redirect_pc = 16'($urandom);
      endcase
      halt  = ($urandom % 12) == 0;
      start = ($urandom % 3) == 0;
      reset = ($urandom % 200) == 0;
      p_red = redirect;
      p_rst = reset;
      step();
      if (!busy || ir_valid || p_red || p_rst) stall = 0;
      else stall++;
      if (stall > 4) begin
        chk("liveness_stall", 32'(stall), 32'd4);
        stall = 0;
      end
    end
    reset = 1'b0; redirect = 1'b0; halt = 1'b0; start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
